// File: rtl/multi_sine_gen.sv
// Time-multiplexed NCH-channel recursive sine oscillator.
// One shared rotation datapath walks the channels once per tick (IDLE->RUN->SUM),
// applies a per-channel gain and finishes with a channel-averaged mix sample.
module multi_sine_gen #(
  parameter int WL  = 16,
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              tick_i,
  input  logic [NCH-1:0]    load_i,
  input  logic [NCH*WL-1:0] cos_w_i,
  input  logic [NCH*WL-1:0] sin_w_i,
  input  logic [NCH*8-1:0]  gain_i,
  output logic              busy_o,
  output logic              sine_valid_o,
  output logic [CW-1:0]     sine_ch_o,
  output logic [WL-1:0]     sine_o,
  output logic              mix_valid_o,
  output logic [WL-1:0]     mix_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {IDLE, RUN, SUM} state_t;

  localparam logic signed [WL-1:0] MAXW = {1'b0, {(WL-1){1'b1}}};
  localparam logic signed [WL-1:0] MINW = -MAXW;

  state_t                    state_q, state_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic signed [WL+CW-1:0]   acc_q, acc_d;
  logic signed [WL-1:0]      s_q [NCH];
  logic signed [WL-1:0]      c_q [NCH];
  logic signed [WL-1:0]      s_d [NCH];
  logic signed [WL-1:0]      c_d [NCH];
  logic [NCH-1:0]            pending_q, pending_d;
  logic signed [WL-1:0]      sine_q, sine_d, mix_q, mix_d;
  logic [CW-1:0]             sine_ch_q, sine_ch_d;
  logic                      sine_valid_q, sine_valid_d;
  logic                      mix_valid_q, mix_valid_d;
  logic                      overrun_q, overrun_d;

  // Channel-selected operands from the packed coefficient buses
  logic [NCH-1:0][WL-1:0] cos_arr, sin_arr;
  logic [NCH-1:0][7:0]    gain_arr;
  assign cos_arr  = cos_w_i;
  assign sin_arr  = sin_w_i;
  assign gain_arr = gain_i;

  logic signed [WL-1:0]   cos_cur, sin_cur, s_cur, c_cur;
  logic signed [2*WL-1:0] m_sc, m_cs, m_cc, m_ss;
  logic signed [2*WL:0]   p_s, p_c;
  logic signed [WL-1:0]   s_rot, c_rot, s_new;
  logic [8:0]             g1;
  logic signed [WL+9:0]   scaled;
  logic signed [WL-1:0]   sine_new;

  function automatic logic signed [WL-1:0] sat(input logic signed [2*WL:0] v);
    if (v > (2*WL+1)'(MAXW))      return MAXW;
    else if (v < (2*WL+1)'(MINW)) return MINW;
    else                          return WL'(v);
  endfunction

  assign cos_cur = cos_arr[ch_q];
  assign sin_cur = sin_arr[ch_q];
  assign s_cur   = s_q[ch_q];
  assign c_cur   = c_q[ch_q];
  assign m_sc    = s_cur * cos_cur;
  assign m_cs    = c_cur * sin_cur;
  assign m_cc    = c_cur * cos_cur;
  assign m_ss    = s_cur * sin_cur;
  assign p_s     = (2*WL+1)'(m_sc) + (2*WL+1)'(m_cs);
  assign p_c     = (2*WL+1)'(m_cc) - (2*WL+1)'(m_ss);
  assign s_rot   = sat(p_s >>> (WL-1));
  assign c_rot   = sat(p_c >>> (WL-1));
  // A pending reload restarts the channel at phase 0 (s=0, c=max)
  assign s_new   = pending_q[ch_q] ? '0 : s_rot;
  // gain+1 spans 1..256 so gain 255 is unity after the >>>8
  assign g1       = {1'b0, gain_arr[ch_q]} + 9'd1;
  assign scaled   = s_new * $signed({1'b0, g1});
  assign sine_new = WL'(scaled >>> 8);

  // Busy also covers the mix presentation cycle, so a tick there counts as overrun
  assign busy_o       = (state_q != IDLE) | mix_valid_q;
  assign sine_valid_o = sine_valid_q;
  assign sine_ch_o    = sine_ch_q;
  assign sine_o       = sine_q;
  assign mix_valid_o  = mix_valid_q;
  assign mix_o        = mix_q;
  assign overrun_o    = overrun_q;

  // State and datapath registers, synchronous reset clears everything
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      acc_q        <= '0;
      pending_q    <= '0;
      sine_q       <= '0;
      sine_ch_q    <= '0;
      sine_valid_q <= 1'b0;
      mix_q        <= '0;
      mix_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        s_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      acc_q        <= acc_d;
      pending_q    <= pending_d;
      sine_q       <= sine_d;
      sine_ch_q    <= sine_ch_d;
      sine_valid_q <= sine_valid_d;
      mix_q        <= mix_d;
      mix_valid_q  <= mix_valid_d;
      overrun_q    <= overrun_d;
      for (int k = 0; k < NCH; k++) begin
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  // Next-state: walk channels, then one SUM cycle; en low aborts
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (tick_i && en_i && !mix_valid_q) state_d = RUN;
      RUN: begin
        if (!en_i)                    state_d = IDLE;
        else if (ch_q == CW'(NCH-1))  state_d = SUM;
      end
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and channel state updates for the current FSM cycle
  always_comb begin
    ch_d         = ch_q;
    acc_d        = acc_q;
    pending_d    = pending_q | load_i;
    sine_d       = sine_q;
    sine_ch_d    = sine_ch_q;
    sine_valid_d = 1'b0;
    mix_d        = mix_q;
    mix_valid_d  = 1'b0;
    overrun_d    = overrun_q | (tick_i & en_i & busy_o);
    for (int k = 0; k < NCH; k++) begin
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
    end
    unique case (state_q)
      IDLE: begin
        if (tick_i && en_i && !mix_valid_q) begin
          ch_d  = '0;
          acc_d = '0;
        end
      end
      RUN: begin
        if (en_i) begin
          if (pending_q[ch_q]) begin
            s_d[ch_q] = '0;
            c_d[ch_q] = MAXW;
            // a load landing on this channel now survives into next round
            pending_d[ch_q] = load_i[ch_q];
          end else begin
            s_d[ch_q] = s_rot;
            c_d[ch_q] = c_rot;
          end
          sine_d       = sine_new;
          sine_ch_d    = ch_q;
          sine_valid_d = 1'b1;
          acc_d        = acc_q + (WL+CW)'(sine_new);
          ch_d         = ch_q + CW'(1);
        end
      end
      SUM: begin
        if (en_i) begin
          mix_d       = WL'(acc_q >>> CW);
          mix_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_sine_gen.sv
// Scoreboard bench for multi_sine_gen: the driver computes each round with an
// arithmetic reference model and queues expected samples; a monitor checks them.
module tb_multi_sine_gen;
  localparam int WL = 16, NCH = 4, CW = 2;
  localparam longint MAXP = 32767;

  logic clk = 1'b0;
  logic reset_i, en_i, tick_i;
  logic [NCH-1:0] load_i;
  logic [NCH*WL-1:0] cos_w_i, sin_w_i;
  logic [NCH*8-1:0] gain_i;
  logic busy_o, sine_valid_o, mix_valid_o, overrun_o;
  logic [CW-1:0] sine_ch_o;
  logic [WL-1:0] sine_o, mix_o;

  multi_sine_gen #(.WL(WL), .NCH(NCH)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .tick_i(tick_i), .load_i(load_i),
    .cos_w_i(cos_w_i), .sin_w_i(sin_w_i), .gain_i(gain_i), .busy_o(busy_o),
    .sine_valid_o(sine_valid_o), .sine_ch_o(sine_ch_o), .sine_o(sine_o),
    .mix_valid_o(mix_valid_o), .mix_o(mix_o), .overrun_o(overrun_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; longint val; int cyc; } exp_t;
  exp_t sq[$];
  exp_t mq[$];
  int checks = 0, errors = 0;

  int cw[NCH], sw[NCH], gn[NCH];
  longint ms[NCH], mc[NCH];
  bit mp[NCH];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXP) return MAXP;
    if (v < -MAXP) return -MAXP;
    return v;
  endfunction

  task automatic drive_cfg();
    for (int k = 0; k < NCH; k++) begin
      cos_w_i[k*WL +: WL] = WL'(cw[k]);
      sin_w_i[k*WL +: WL] = WL'(sw[k]);
      gain_i[k*8 +: 8]    = 8'(gn[k]);
    end
  endtask

  // Reference: advance the first nproc channels one sample, queue expectations
  task automatic model_round(input int nproc, input int t);
    longint acc = 0, ps, pc, sv;
    for (int k = 0; k < nproc; k++) begin
      if (mp[k]) begin
        ms[k] = 0; mc[k] = MAXP; mp[k] = 0;
      end else begin
        ps = ms[k] * cw[k] + mc[k] * sw[k];
        pc = mc[k] * cw[k] - ms[k] * sw[k];
        ms[k] = sat(fdiv(ps, 32768));
        mc[k] = sat(fdiv(pc, 32768));
      end
      sv = fdiv(ms[k] * (gn[k] + 1), 256);
      acc += sv;
      sq.push_back('{k, sv, t + 1 + k});
    end
    if (nproc == NCH) mq.push_back('{0, fdiv(acc, NCH), t + 1 + NCH});
  endtask

  // Monitor: every presented sample must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    if (sine_valid_o) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sine_unexpected: got ch %0d val %0d, required none", sine_ch_o, $signed(sine_o));
      end else begin
        e = sq.pop_front();
        chk("sine_ch", longint'(sine_ch_o), e.ch);
        chk("sine", $signed(sine_o), e.val);
        chk("sine_cycle", cyc, e.cyc);
      end
    end
    if (mix_valid_o) begin
      if (mq.size() == 0) begin
        checks++; errors++;
        $display("FAIL mix_unexpected: got %0d, required none", $signed(mix_o));
      end else begin
        e = mq.pop_front();
        chk("mix", $signed(mix_o), e.val);
        chk("mix_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy_o; i++) @(negedge clk);
    if (busy_o) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_load(input logic [NCH-1:0] m);
    wait_idle();
    load_i = m;
    for (int k = 0; k < NCH; k++) if (m[k]) mp[k] = 1;
    @(negedge clk);
    load_i = '0;
  endtask

  // a < NCH: drop en so only channels 0..a-1 get processed; dup: 2nd tick at T+2
  task automatic run_round(input int a, input bit dup);
    int t;
    wait_idle();
    drive_cfg();
    t = cyc + 1;
    model_round(a, t);
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    if (a < NCH) begin
      repeat (a) @(negedge clk);
      en_i = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy_o, 0);
      en_i = 1'b1;
    end else begin
      chk("busy_start", busy_o, 1);
      while (cyc < t + 1 + NCH) begin
        @(negedge clk);
        tick_i = (dup && cyc == t + 1);
      end
      tick_i = 1'b0;
      chk("busy_mix", busy_o, 1);
      chk("mix_valid_now", mix_valid_o, 1);
      @(negedge clk);
      chk("busy_end", busy_o, 0);
    end
  endtask

  task automatic set_all(input int c, input int s, input int g);
    for (int k = 0; k < NCH; k++) begin cw[k] = c; sw[k] = s; gn[k] = g; end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_sine_valid"}, sine_valid_o, 0);
    chk({tag, "_sine"}, sine_o, 0);
    chk({tag, "_sine_ch"}, sine_ch_o, 0);
    chk({tag, "_mix_valid"}, mix_valid_o, 0);
    chk({tag, "_mix"}, mix_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; en_i = 1'b1; tick_i = 1'b0; load_i = '0;
    set_all(0, 0, 0);
    for (int k = 0; k < NCH; k++) begin ms[k] = 0; mc[k] = 0; mp[k] = 0; end
    drive_cfg();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_i = 1'b0;
    @(negedge clk);

    // tick while disabled is ignored and does not flag overrun
    en_i = 1'b0; tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0; en_i = 1'b1;
    @(negedge clk);
    chk("en0_busy", busy_o, 0);
    chk("en0_overrun", overrun_o, 0);

    // no load yet: every sample is zero
    set_all(12345, -2222, 200);
    run_round(NCH, 0);

    // ch0 quarter-turn oscillator, unity gain
    set_all(0, 0, 0);
    cw[0] = 0; sw[0] = 32767; gn[0] = 255;
    do_load(4'b0001);
    repeat (3) run_round(NCH, 0);

    // half gain
    gn[0] = 127;
    do_load(4'b0001);
    repeat (2) run_round(NCH, 0);

    // all channels identical
    set_all(0, 32767, 255);
    do_load(4'b1111);
    repeat (2) run_round(NCH, 0);

    // only ch0 rotating, others stationary
    set_all(32767, 0, 255);
    cw[0] = 0; sw[0] = 32767;
    do_load(4'b1111);
    repeat (2) run_round(NCH, 0);

    // second tick during a round
    chk("overrun_before", overrun_o, 0);
    run_round(NCH, 1);
    chk("overrun_set", overrun_o, 1);

    // enable dropped after two channels
    run_round(2, 0);
    run_round(NCH, 0);

    // reset mid-round, with reloads pending beforehand
    set_all(32767, 32767, 255);
    do_load(4'b1111);
    wait_idle();
    drive_cfg();
    model_round(1, cyc + 1);
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    for (int k = 0; k < NCH; k++) begin ms[k] = 0; mc[k] = 0; mp[k] = 0; end
    check_zero_outputs("midreset");
    repeat (2) run_round(NCH, 0);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < NCH; k++) begin
        cw[k] = int'($urandom_range(65535)) - 32768;
        sw[k] = int'($urandom_range(65535)) - 32768;
        gn[k] = int'($urandom_range(255));
      end
      if ($urandom_range(3) == 0) do_load(NCH'($urandom_range((1 << NCH) - 1)));
      if ($urandom_range(7) == 0) run_round(int'($urandom_range(NCH - 1)), 0);
      else run_round(NCH, $urandom_range(4) == 0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sine_queue_drained", sq.size(), 0);
    chk("mix_queue_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
